// File: rtl/add_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

    // Control FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Number of digit cycles needed to process one operand
    function automatic int calc_ndig(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end else begin
            return width / digit;
        end
    endfunction

    // Digit counter width: clog2(ndig), but never narrower than one bit
    function automatic int calc_cnt_w(input int ndig);
        if (ndig <= 2) begin
            return 1;
        end else begin
            return $clog2(ndig);
        end
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from a chain of full_adder cells.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[DIGIT];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the digit adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_sub_digit_serial.sv
// Digit-serial signed/unsigned adder-subtractor with valid/ready handshakes.
// One shared DIGIT-bit adder processes the operands LSB-digit first over
// NDIG = WIDTH/DIGIT cycles; result and flags are registered in DONE.
module add_sub_digit_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("add_sub_digit_serial: WIDTH must be a positive multiple of DIGIT");
    end

    // Control state
    state_e state_q, state_d;

    // Datapath registers
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    // Registered outputs
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    // Combinational helpers
    logic [DIGIT-1:0] dig_sum_s;
    logic             dig_cout_s;
    logic [WIDTH-1:0] b_in_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    // B is stored pre-inverted for subtract; the +1 comes from carry-in
    assign b_in_s = sub ? ~b : b;
    assign last_s = (cnt_q == LAST_CNT);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dig_sum_s),
        .cout (dig_cout_s)
    );

    // With a single digit there is nothing left to shift
    if (DIGIT == WIDTH) begin : g_single_digit
        assign a_next_s   = '0;
        assign b_next_s   = '0;
        assign res_next_s = dig_sum_s;
    end else begin : g_multi_digit
        assign a_next_s   = {{DIGIT{1'b0}}, a_sh_q[WIDTH-1:DIGIT]};
        assign b_next_s   = {{DIGIT{1'b0}}, b_sh_q[WIDTH-1:DIGIT]};
        assign res_next_s = {dig_sum_s, res_sh_q[WIDTH-1:DIGIT]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through digits, wait for consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: load at accept, shift one digit per BUSY cycle
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b_in_s;
                    res_sh_d = '0;
                    carry_d  = sub;
                    cnt_d    = '0;
                    // Operand sign bits kept aside for the overflow flag
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b_in_s[WIDTH-1];
                end else begin
                    a_sh_d = a_sh_q;
                end
            end
            ST_BUSY: begin
                a_sh_d   = a_next_s;
                b_sh_d   = b_next_s;
                res_sh_d = res_next_s;
                carry_d  = dig_cout_s;
                if (last_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    // Output next values: handshake flags follow the next state, result and
    // flags are captured on the last digit and held until the next operation
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if ((state_q == ST_BUSY) && last_s) begin
            result_d    = res_next_s;
            carry_out_d = dig_cout_s;
            overflow_d  = (a_msb_q == b_msb_q) && (res_next_s[WIDTH-1] != a_msb_q);
            zero_d      = (res_next_s == '0);
        end else begin
            result_d = result_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_digit_serial.sv
// Self-checking bench: three instances (DIGIT = 4, 1, 16) share the operand
// inputs; directed vectors, backpressure, mid-operation reset, random ops.
module tb_add_sub_digit_serial;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          out_ready;

    // index 0: DIGIT=4, index 1: DIGIT=1, index 2: DIGIT=16
    logic [2:0]    ir;
    logic [2:0]    ov;
    logic [2:0]    co;
    logic [2:0]    vf;
    logic [2:0]    zr;
    logic [W-1:0]  res [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add_sub_digit_serial #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res[0]), .carry_out(co[0]), .overflow(vf[0]), .zero(zr[0]));

    add_sub_digit_serial #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res[1]), .carry_out(co[1]), .overflow(vf[1]), .zero(zr[1]));

    add_sub_digit_serial #(.WIDTH(W), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res[2]), .carry_out(co[2]), .overflow(vf[2]), .zero(zr[2]));

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] eres;
        logic         ecarry;
        logic         eovf;
        logic         ezero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", nm, idx, act, exp, $time);
        end
    endtask

    // Independent reference: full-width add with explicit inversion
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         v;
        bb = ms ? (~mb) : mb;
        s  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
        v  = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
        return {s[W-1:0], s[W], v, (s[W-1:0] == {W{1'b0}})};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ir !== 3'b111) && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        if (ir !== 3'b111) chk("in_ready_wait", 0, {29'd0, ir}, 32'd7);
    endtask

    // Issue one operation to all instances (out_ready held low) and check
    // each instance's latency and outputs against the expected values
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input logic [W-1:0] eres, input logic ec, input logic ev, input logic ez);
        int       lat [3];
        int       exp_lat [3];
        logic [2:0] seen;
        int       cyc;
        exp_lat = '{4, 16, 1};
        wait_idle();
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // keep in_valid high with different operands: must be ignored
        a = ~ta; b = ta ^ tb ^ 16'h5A5A; sub = ~ts;
        seen = 3'b000;
        cyc  = 0;
        for (int i = 0; i < 3; i++) lat[i] = -1;
        while ((seen != 3'b111) && (cyc < 40)) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = cyc;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("latency", i, lat[i], exp_lat[i]);
            chk("result", i, {16'd0, res[i]}, {16'd0, eres});
            chk("carry_out", i, {31'd0, co[i]}, {31'd0, ec});
            chk("overflow", i, {31'd0, vf[i]}, {31'd0, ev});
            chk("zero", i, {31'd0, zr[i]}, {31'd0, ez});
            chk("in_ready_done", i, {31'd0, ir[i]}, 32'd0);
        end
    endtask

    // Accept the results and check every instance is back in IDLE next cycle
    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", 0, {29'd0, ov}, 32'd0);
        chk("in_ready_after_release", 0, {29'd0, ir}, 32'd7);
    endtask

    initial begin
        logic [W+2:0] m;
        logic [W-1:0] ra, rb;
        logic         rs;

        vecs[0] = '{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_in_ready", i, {31'd0, ir[i]}, 32'd1);
            chk("reset_out_valid", i, {31'd0, ov[i]}, 32'd0);
            chk("reset_result", i, {16'd0, res[i]}, 32'd0);
            chk("reset_flags", i, {29'd0, co[i], vf[i], zr[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].va, vecs[v].vb, vecs[v].vsub,
                  vecs[v].eres, vecs[v].ecarry, vecs[v].eovf, vecs[v].ezero);
            release_out();
        end

        // Backpressure: hold out_ready low for 10 cycles with new operands offered
        do_op(16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            a = 16'(c * 16'h1111); b = 16'hABCD; sub = c[0]; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 0, {31'd0, ov[0]}, 32'd1);
            chk("bp_result", 0, {16'd0, res[0]}, 32'h2224);
            chk("bp_in_ready", 0, {31'd0, ir[0]}, 32'd0);
        end
        release_out();

        // Reset in the middle of an operation (after two digits)
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        release_out();
        wait_idle();
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_in_ready", i, {31'd0, ir[i]}, 32'd1);
            chk("midrst_out_valid", i, {31'd0, ov[i]}, 32'd0);
            chk("midrst_result", i, {16'd0, res[i]}, 32'd0);
            chk("midrst_flags", i, {29'd0, co[i], vf[i], zr[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        release_out();

        // Random operations against the reference model
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(1, 0));
            m  = model(ra, rb, rs);
            do_op(ra, rb, rs, m[W+2:3], m[2], m[1], m[0]);
            release_out();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
